// File: rtl/xbus_crossbar_pkg.sv
// -----------------------------------------------------------------------------
// xbus_crossbar_pkg
// Shared configuration for the xbus interconnect: bus widths (as macros, so
// packed port widths can use them everywhere), the crossbar FSM state type,
// the wait-counter width and a helper that sizes index fields.
// No ports.
// -----------------------------------------------------------------------------
`ifndef XBUS_CONFIG_DEFINED
`define XBUS_CONFIG_DEFINED
`define XADDRW     32
`define XDATAW     32
`define XBYTEC     4
// Read data returned on a miss or a write acknowledge.
`define XERR_RDATA 32'h0000_0000
`endif

package xbus_crossbar_pkg;

    // Crossbar transaction FSM. Exposed on the debug port of the top.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2
    } state_t;

    // Wide enough for RD_LAT up to 7.
    localparam int WAIT_CNT_W = 3;

    // Width of a binary index into n items; never zero so N=1 still works.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/xbus_crossbar_if.sv
// -----------------------------------------------------------------------------
// xbus_crossbar_if
// Bundles the master-side request/response signals and the slave-side
// select/data signals of the xbus crossbar.
//   m_as/m_we/m_be/m_addr/m_wdata : per-master request fields (packed)
//   m_rdata/m_ack/m_err           : shared response, qualified by one-hot m_ack
//   s_cs/s_we/s_be/s_addr/s_wdata : slave selects and shared request fields
//   s_rdata                       : per-slave read data (packed)
// Handshake: a master raises m_as with stable fields and holds it until it
// sees its own m_ack bit high for exactly one cycle; m_rdata and m_err are
// only meaningful in that cycle.
// Modports: master (bus masters), slave (bus slaves), xbar (the crossbar).
// -----------------------------------------------------------------------------
interface xbus_crossbar_if #(
    parameter int N_MASTER = 2,
    parameter int N_SLAVE  = 4
);
    logic [N_MASTER-1:0]          m_as;
    logic [N_MASTER-1:0]          m_we;
    logic [N_MASTER*`XBYTEC-1:0]  m_be;
    logic [N_MASTER*`XADDRW-1:0]  m_addr;
    logic [N_MASTER*`XDATAW-1:0]  m_wdata;
    logic [`XDATAW-1:0]           m_rdata;
    logic [N_MASTER-1:0]          m_ack;
    logic                         m_err;

    logic [N_SLAVE-1:0]           s_cs;
    logic                         s_we;
    logic [`XBYTEC-1:0]           s_be;
    logic [`XADDRW-1:0]           s_addr;
    logic [`XDATAW-1:0]           s_wdata;
    logic [N_SLAVE*`XDATAW-1:0]   s_rdata;

    modport master (
        output m_as, m_we, m_be, m_addr, m_wdata,
        input  m_rdata, m_ack, m_err
    );

    modport slave (
        input  s_cs, s_we, s_be, s_addr, s_wdata,
        output s_rdata
    );

    modport xbar (
        input  m_as, m_we, m_be, m_addr, m_wdata, s_rdata,
        output m_rdata, m_ack, m_err, s_cs, s_we, s_be, s_addr, s_wdata
    );
endinterface

// File: rtl/xbus_rr_arbiter.sv
// -----------------------------------------------------------------------------
// xbus_rr_arbiter
// Combinational round-robin arbiter. The search for a set request starts at
// index ptr and wraps around; the first request found wins.
//   req     in  N   request vector
//   ptr     in  IW  index with highest priority this cycle
//   gnt     out N   one-hot grant (all zero when no request)
//   gnt_idx out IW  binary index of the granted request (0 when none)
// -----------------------------------------------------------------------------
module xbus_rr_arbiter
    import xbus_crossbar_pkg::*;
#(
    parameter  int N  = 2,
    localparam int IW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);

    always_comb begin : search
        logic          found;
        logic [IW:0]   cand;
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        cand    = '0;
        for (int off = 0; off < N; off++) begin
            // Candidate index = (ptr + off) mod N, with one extra bit so the
            // sum cannot overflow before the wrap.
            cand = {1'b0, ptr} + (IW+1)'(off);
            if (cand >= (IW+1)'(N)) begin
                cand = cand - (IW+1)'(N);
            end
            if (!found && req[cand[IW-1:0]]) begin
                found                = 1'b1;
                gnt[cand[IW-1:0]]    = 1'b1;
                gnt_idx              = cand[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/xbus_crossbar.sv
// -----------------------------------------------------------------------------
// xbus_crossbar
// N_MASTER x N_SLAVE xbus interconnect with round-robin arbitration, a
// base/mask address map, a fixed RD_LAT read latency and a bus-error response
// for unmapped addresses. One transaction is in flight at a time.
//   clk        in   system clock
//   rst        in   asynchronous, active-low reset
//   bus        xbar modport of xbus_crossbar_if (master and slave sides)
//   dbg_state  out  current FSM state
//   dbg_rr_ptr out  round-robin priority pointer
//   dbg_grant  out  index of the master owning the current transaction
// Timing: m_as sampled in cycle 0, s_cs in cycle 1, m_ack in cycle 2+RD_LAT.
// -----------------------------------------------------------------------------
module xbus_crossbar
    import xbus_crossbar_pkg::*;
#(
    parameter  int N_MASTER = 2,
    parameter  int N_SLAVE  = 4,
    parameter  int RD_LAT   = 1,
    parameter  logic [N_SLAVE*`XADDRW-1:0] SLV_BASE =
        {32'h1000_0100, 32'h1000_0000, 32'h0001_0000, 32'h0000_1000},
    parameter  logic [N_SLAVE*`XADDRW-1:0] SLV_MASK =
        {32'hFFFF_FF00, 32'hFFFF_FF00, 32'hFFFF_0000, 32'hFFFF_F000},
    localparam int MIW = idx_width(N_MASTER)
) (
    input  logic            clk,
    input  logic            rst,
    xbus_crossbar_if.xbar   bus,
    output state_t          dbg_state,
    output logic [MIW-1:0]  dbg_rr_ptr,
    output logic [MIW-1:0]  dbg_grant
);

    localparam int SIW = idx_width(N_SLAVE);
    localparam logic [WAIT_CNT_W-1:0] LAT = WAIT_CNT_W'(RD_LAT);

    state_t                 state, state_next;
    logic                   start, finish;

    logic [MIW-1:0]         rr_ptr, grant;
    logic                   lat_we;
    logic [`XBYTEC-1:0]     lat_be;
    logic [`XADDRW-1:0]     lat_addr;
    logic [`XDATAW-1:0]     lat_wdata;
    logic [SIW-1:0]         lat_slv;
    logic                   lat_hit;
    logic [WAIT_CNT_W-1:0]  wait_cnt;

    logic [N_MASTER-1:0]    ack_q;
    logic                   err_q;
    logic [`XDATAW-1:0]     rdata_q;

    // ---------------------------------------------------------------- arbiter
    // A master being acknowledged this cycle still has m_as high (it only
    // drops it after seeing the ack), so it is kept out of this round.
    logic [N_MASTER-1:0]    eligible;
    logic [N_MASTER-1:0]    arb_gnt;
    logic [MIW-1:0]         arb_idx;

    assign eligible = bus.m_as & ~ack_q;

    xbus_rr_arbiter #(.N(N_MASTER)) u_arb (
        .req     (eligible),
        .ptr     (rr_ptr),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx)
    );

    // Fields of the arbitration winner.
    logic                   win_we;
    logic [`XBYTEC-1:0]     win_be;
    logic [`XADDRW-1:0]     win_addr;
    logic [`XDATAW-1:0]     win_wdata;

    assign win_we    = bus.m_we[arb_idx];
    assign win_be    = bus.m_be[arb_idx*`XBYTEC +: `XBYTEC];
    assign win_addr  = bus.m_addr[arb_idx*`XADDRW +: `XADDRW];
    assign win_wdata = bus.m_wdata[arb_idx*`XDATAW +: `XDATAW];

    // --------------------------------------------------------- address decode
    logic [N_SLAVE-1:0]     hit_vec;
    logic [SIW-1:0]         dec_slv;
    logic                   dec_hit;

    for (genvar i = 0; i < N_SLAVE; i++) begin : g_decode
        assign hit_vec[i] =
            (win_addr & SLV_MASK[i*`XADDRW +: `XADDRW]) == SLV_BASE[i*`XADDRW +: `XADDRW];
    end

    // Scan from the top down so the lowest matching index is the one kept.
    always_comb begin
        dec_hit = 1'b0;
        dec_slv = '0;
        for (int i = N_SLAVE - 1; i >= 0; i--) begin
            if (hit_vec[i]) begin
                dec_hit = 1'b1;
                dec_slv = SIW'(i);
            end
        end
    end

    // -------------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        start      = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (|arb_gnt) begin
                    start      = 1'b1;
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                state_next = WAIT;
            end
            WAIT: begin
                if (wait_cnt == WAIT_CNT_W'(1)) begin
                    finish     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // --------------------------------------------------------------- datapath
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr    <= '0;
            grant     <= '0;
            lat_we    <= 1'b0;
            lat_be    <= '0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_slv   <= '0;
            lat_hit   <= 1'b0;
            wait_cnt  <= '0;
            ack_q     <= '0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
        end else begin
            ack_q <= '0;
            err_q <= 1'b0;

            if (start) begin
                grant     <= arb_idx;
                lat_we    <= win_we;
                lat_be    <= win_be;
                lat_addr  <= win_addr;
                lat_wdata <= win_wdata;
                lat_slv   <= dec_slv;
                lat_hit   <= dec_hit;
            end

            if (state == ACCESS) begin
                wait_cnt <= LAT;
            end else if (state == WAIT) begin
                wait_cnt <= wait_cnt - WAIT_CNT_W'(1);
            end

            if (finish) begin
                ack_q[grant] <= 1'b1;
                err_q        <= !lat_hit;
                rdata_q      <= (lat_hit && !lat_we) ?
                                bus.s_rdata[lat_slv*`XDATAW +: `XDATAW] : `XERR_RDATA;
                rr_ptr       <= (grant == MIW'(N_MASTER - 1)) ? '0 : grant + 1'b1;
            end
        end
    end

    // ---------------------------------------------------------------- outputs
    // Slave-side signals exist only during ACCESS and are zero otherwise, so
    // an asynchronous reset clears them immediately through the state.
    assign bus.s_cs    = (state == ACCESS && lat_hit) ? (N_SLAVE'(1) << lat_slv) : '0;
    assign bus.s_we    = (state == ACCESS) && lat_we;
    assign bus.s_be    = (state == ACCESS) ? lat_be    : '0;
    assign bus.s_addr  = (state == ACCESS) ? lat_addr  : '0;
    assign bus.s_wdata = (state == ACCESS) ? lat_wdata : '0;

    assign bus.m_ack   = ack_q;
    assign bus.m_err   = err_q;
    assign bus.m_rdata = rdata_q;

    assign dbg_state   = state;
    assign dbg_rr_ptr  = rr_ptr;
    assign dbg_grant   = grant;

endmodule

// File: tb/tb_xbus_crossbar.sv
// -----------------------------------------------------------------------------
// tb_xbus_crossbar
// Directed bench for xbus_crossbar: one instance with default parameters
// (RD_LAT=1) and one with RD_LAT=3. Inputs change 1 time unit after the
// rising edge; outputs are sampled at the same point, i.e. well away from it.
// -----------------------------------------------------------------------------
module tb_xbus_crossbar;
    import xbus_crossbar_pkg::*;

    // ------------------------------------------------------ clock and reset
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    xbus_crossbar_if #(.N_MASTER(2), .N_SLAVE(4)) bus_a ();
    xbus_crossbar_if #(.N_MASTER(2), .N_SLAVE(4)) bus_b ();

    state_t     state_a, state_b;
    logic [0:0] rr_a, grant_a, rr_b, grant_b;

    xbus_crossbar dut_a (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus_a),
        .dbg_state  (state_a),
        .dbg_rr_ptr (rr_a),
        .dbg_grant  (grant_a)
    );

    xbus_crossbar #(.RD_LAT(3)) dut_b (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus_b),
        .dbg_state  (state_b),
        .dbg_rr_ptr (rr_b),
        .dbg_grant  (grant_b)
    );

    // ----------------------------------------------------------- scoreboard
    int n_cmp = 0;
    int n_mis = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // --------------------------------------------------------- driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req_a(input int m, input logic we, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] wdata);
        bus_a.m_we[m]             = we;
        bus_a.m_be[m*4 +: 4]      = be;
        bus_a.m_addr[m*32 +: 32]  = addr;
        bus_a.m_wdata[m*32 +: 32] = wdata;
        bus_a.m_as[m]             = 1'b1;
    endtask

    task automatic drop_a(input int m);
        bus_a.m_as[m] = 1'b0;
    endtask

    logic [1:0] exp_ack;

    // ------------------------------------------------------------- stimulus
    initial begin
        rst           = 1'b0;
        bus_a.m_as    = '0;
        bus_a.m_we    = '0;
        bus_a.m_be    = '0;
        bus_a.m_addr  = '0;
        bus_a.m_wdata = '0;
        bus_a.s_rdata = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'hDEAD_BEEF};
        bus_b.m_as    = '0;
        bus_b.m_we    = '0;
        bus_b.m_be    = '0;
        bus_b.m_addr  = '0;
        bus_b.m_wdata = '0;
        bus_b.s_rdata = {32'h0, 32'h0, 32'h0, 32'hAAAA_0001};

        // ---- reset values
        tick();
        tick();
        check("rst_state",   state_a, IDLE);
        check("rst_rr_ptr",  rr_a, 0);
        check("rst_grant",   grant_a, 0);
        check("rst_m_ack",   bus_a.m_ack, 0);
        check("rst_m_err",   bus_a.m_err, 0);
        check("rst_m_rdata", bus_a.m_rdata, 0);
        check("rst_s_cs",    bus_a.s_cs, 0);
        check("rst_s_we",    bus_a.s_we, 0);
        check("rst_s_be",    bus_a.s_be, 0);
        check("rst_s_addr",  bus_a.s_addr, 0);
        check("rst_s_wdata", bus_a.s_wdata, 0);
        check("rst_b_m_ack", bus_b.m_ack, 0);
        rst = 1'b1;
        tick();

        // ---- single read, M0 -> slave 0
        req_a(0, 1'b0, 4'hF, 32'h0000_1004, 32'h0);
        tick();
        check("rd_s_cs",   bus_a.s_cs, 4'b0001);
        check("rd_s_addr", bus_a.s_addr, 32'h0000_1004);
        check("rd_s_we",   bus_a.s_we, 0);
        check("rd_state1", state_a, ACCESS);
        tick();
        check("rd_s_cs_c2",  bus_a.s_cs, 0);
        check("rd_ack_c2",   bus_a.m_ack, 0);
        check("rd_state2",   state_a, WAIT);
        tick();
        check("rd_ack",   bus_a.m_ack, 2'b01);
        check("rd_rdata", bus_a.m_rdata, 32'hDEAD_BEEF);
        check("rd_err",   bus_a.m_err, 0);
        drop_a(0);
        tick();
        check("rd_ack_clr", bus_a.m_ack, 0);
        check("rd_rr_ptr",  rr_a, 1);

        // ---- unmapped read, M1
        req_a(1, 1'b0, 4'hF, 32'h2000_0000, 32'h0);
        tick();
        check("um_s_cs_c1", bus_a.s_cs, 0);
        tick();
        check("um_s_cs_c2", bus_a.s_cs, 0);
        check("um_ack_c2",  bus_a.m_ack, 0);
        tick();
        check("um_ack",   bus_a.m_ack, 2'b10);
        check("um_err",   bus_a.m_err, 1);
        check("um_rdata", bus_a.m_rdata, 0);
        check("um_s_cs",  bus_a.s_cs, 0);
        drop_a(1);
        tick();
        check("um_rr_ptr", rr_a, 0);

        // ---- byte write, M0 -> slave 2
        req_a(0, 1'b1, 4'b0010, 32'h1000_0000, 32'h0000_AB00);
        tick();
        check("wr_s_cs",    bus_a.s_cs, 4'b0100);
        check("wr_s_we",    bus_a.s_we, 1);
        check("wr_s_be",    bus_a.s_be, 4'b0010);
        check("wr_s_wdata", bus_a.s_wdata, 32'h0000_AB00);
        check("wr_s_addr",  bus_a.s_addr, 32'h1000_0000);
        tick();
        tick();
        check("wr_ack",   bus_a.m_ack, 2'b01);
        check("wr_err",   bus_a.m_err, 0);
        check("wr_rdata", bus_a.m_rdata, 0);
        drop_a(0);
        tick();

        // ---- read of slave 3 by M1, request fields change while granted
        req_a(1, 1'b0, 4'hF, 32'h1000_0140, 32'h0);
        tick();
        bus_a.m_addr[32 +: 32] = 32'h0000_1000;
        bus_a.m_we[1]          = 1'b1;
        #1;
        check("chg_s_cs",   bus_a.s_cs, 4'b1000);
        check("chg_s_addr", bus_a.s_addr, 32'h1000_0140);
        check("chg_s_we",   bus_a.s_we, 0);
        tick();
        tick();
        check("chg_ack",   bus_a.m_ack, 2'b10);
        check("chg_rdata", bus_a.m_rdata, 32'h3333_3333);
        drop_a(1);
        tick();

        // ---- contention: both masters request continuously
        req_a(0, 1'b0, 4'hF, 32'h0000_1004, 32'h0);
        req_a(1, 1'b0, 4'hF, 32'h0001_0008, 32'h0);
        for (int c = 1; c <= 12; c++) begin
            tick();
            exp_ack = (c == 3 || c == 9) ? 2'b01 : (c == 6 || c == 12) ? 2'b10 : 2'b00;
            check($sformatf("ct_ack_c%0d", c), bus_a.m_ack, exp_ack);
            if (c == 1 || c == 7) check($sformatf("ct_cs_c%0d", c), bus_a.s_cs, 4'b0001);
            if (c == 4 || c == 10) check($sformatf("ct_cs_c%0d", c), bus_a.s_cs, 4'b0010);
            if (exp_ack == 2'b01) check($sformatf("ct_rd_c%0d", c), bus_a.m_rdata, 32'hDEAD_BEEF);
            if (exp_ack == 2'b10) check($sformatf("ct_rd_c%0d", c), bus_a.m_rdata, 32'h1111_1111);
        end
        drop_a(0);
        drop_a(1);
        tick();
        check("ct_idle", state_a, IDLE);
        check("ct_ack_end", bus_a.m_ack, 0);

        // ---- reset in the middle of a transaction
        req_a(0, 1'b0, 4'hF, 32'h0000_1004, 32'h0);
        tick();
        tick();
        tick();
        drop_a(0);
        tick();
        check("mr_pre_rr", rr_a, 1);
        req_a(0, 1'b0, 4'hF, 32'h0000_1004, 32'h0);
        tick();
        tick();
        check("mr_in_wait", state_a, WAIT);
        #2;
        rst = 1'b0;
        #1;
        check("mr_state",  state_a, IDLE);
        check("mr_rr_ptr", rr_a, 0);
        check("mr_grant",  grant_a, 0);
        check("mr_ack",    bus_a.m_ack, 0);
        check("mr_rdata",  bus_a.m_rdata, 0);
        check("mr_s_cs",   bus_a.s_cs, 0);
        req_a(1, 1'b0, 4'hF, 32'h0001_0008, 32'h0);
        tick();
        check("mr_ack_h1", bus_a.m_ack, 0);
        tick();
        check("mr_ack_h2", bus_a.m_ack, 0);
        rst = 1'b1;
        tick();
        check("mr_cs_m0", bus_a.s_cs, 4'b0001);
        tick();
        check("mr_ack_c2", bus_a.m_ack, 0);
        tick();
        check("mr_ack_m0", bus_a.m_ack, 2'b01);
        drop_a(0);
        tick();
        check("mr_cs_m1", bus_a.s_cs, 4'b0010);
        tick();
        tick();
        check("mr_ack_m1", bus_a.m_ack, 2'b10);
        drop_a(1);
        tick();

        // ---- RD_LAT=3 instance: capture happens on the last wait cycle only
        bus_b.m_we[0]       = 1'b0;
        bus_b.m_be[3:0]     = 4'hF;
        bus_b.m_addr[31:0]  = 32'h0000_1004;
        bus_b.m_as[0]       = 1'b1;
        tick();
        check("l3_cs_c1", bus_b.s_cs, 4'b0001);
        bus_b.s_rdata[31:0] = 32'h5555_0002;
        tick();
        check("l3_ack_c2", bus_b.m_ack, 0);
        tick();
        check("l3_ack_c3",   bus_b.m_ack, 0);
        check("l3_rdata_c3", bus_b.m_rdata, 0);
        bus_b.s_rdata[31:0] = 32'hCAFE_0004;
        tick();
        check("l3_ack_c4", bus_b.m_ack, 0);
        tick();
        check("l3_ack_c5",   bus_b.m_ack, 2'b01);
        check("l3_rdata_c5", bus_b.m_rdata, 32'hCAFE_0004);
        check("l3_err_c5",   bus_b.m_err, 0);
        bus_b.s_rdata[31:0] = 32'hBAD0_0005;
        bus_b.m_as[0]       = 1'b0;
        tick();
        check("l3_ack_c6",   bus_b.m_ack, 0);
        check("l3_rdata_c6", bus_b.m_rdata, 32'hCAFE_0004);

        // ---- final report
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
